// File: rtl/aibcr3_dll_pkg.sv
// Shared encodings for the DLL delay-code controller: FSM states, step
// directions and the phase-detector vote mapping.
package aibcr3_dll_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_e;

  // Conflicting or absent votes carry no information and count as zero.
  function automatic logic signed [1:0] vote_to_signed(input logic up, input logic dn);
    if (up && !dn)      return 2'sb01;
    else if (dn && !up) return 2'sb11;
    else                return 2'sb00;
  endfunction

endpackage

// File: rtl/aibcr3_dll_vote_filt.sv
// Phase-detector vote accumulator: a step request fires when the signed
// running sum reaches +/-(2**FILT_W-1), and the sum restarts from zero.
module aibcr3_dll_vote_filt
  import aibcr3_dll_pkg::*;
#(
  parameter int FILT_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pd_up,
  input  logic pd_dn,
  input  logic clr,
  input  logic hold,
  output logic step_up,
  output logic step_dn
);

  localparam int ACC_W = FILT_W + 1;
  localparam int FTH   = (1 << FILT_W) - 1;
  localparam logic signed [ACC_W-1:0] POS_TH = ACC_W'(FTH);
  localparam logic signed [ACC_W-1:0] NEG_TH = ACC_W'(-FTH);

  logic signed [1:0]       vote;
  logic signed [ACC_W-1:0] vote_ext;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic                    hit_up;
  logic                    hit_dn;

  assign vote     = vote_to_signed(pd_up, pd_dn);
  assign vote_ext = {{(ACC_W-2){vote[1]}}, vote};
  assign acc_nxt  = acc + vote_ext;
  assign hit_up   = (acc_nxt == POS_TH);
  assign hit_dn   = (acc_nxt == NEG_TH);

  // Requests are registered, so the code moves one edge after the deciding vote.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register reading pre-edge values.
    if (rst || clr || hold) begin
      acc     <= '0;
      step_up <= 1'b0;
      step_dn <= 1'b0;
    end else begin
      step_up <= hit_up;
      step_dn <= hit_dn;
      acc     <= (hit_up || hit_dn) ? '0 : acc_nxt;
    end
  end

endmodule

// File: rtl/aibcr3_dll_lock_ctrl.sv
// DLL delay-code controller: steps the delay code from filtered votes and
// declares lock once the code only dithers; optional tracking with loss detect.
module aibcr3_dll_lock_ctrl
  import aibcr3_dll_pkg::*;
#(
  parameter int CODE_W = 7,
  parameter int CNT_W  = 8,
  parameter int FILT_W = 3
) (
  input  logic              clk_dcd,
  input  logic              RST,
  input  logic              dll_en,
  input  logic              pd_up,
  input  logic              pd_dn,
  input  logic [CODE_W-1:0] rb_code_init,
  input  logic [CNT_W-1:0]  rb_lock_win,
  input  logic [FILT_W-1:0] rb_unlock_thr,
  input  logic              rb_cont_cal,
  output logic [CODE_W-1:0] dll_code,
  output logic              dll_lock,
  output logic              lock_lost,
  output logic              code_sat
);

  logic [1:0]        state;
  logic [CNT_W-1:0]  lock_cnt;
  logic [FILT_W-1:0] run_cnt;
  dir_e              last_dir;

  logic              step_up_req;
  logic              step_dn_req;
  logic              track;
  logic              hold;
  logic              step_up;
  logic              step_dn;
  logic              stepping;
  dir_e              step_dir;
  logic              same_dir;
  logic              sat_hit;

  logic [CNT_W:0]    win_eff;
  logic [CNT_W:0]    lock_cnt_nxt;
  logic              lock_hit;
  logic [FILT_W-1:0] run_cnt_nxt;
  logic              loss_hit;

  // Filter runs in ACQUIRE and in tracking LOCKED; otherwise it is parked at zero.
  assign track = (state == ST_LOCKED) && rb_cont_cal;
  assign hold  = (state == ST_IDLE) || ((state == ST_LOCKED) && !rb_cont_cal);

  aibcr3_dll_vote_filt #(
    .FILT_W (FILT_W)
  ) u_vote_filt (
    .clk     (clk_dcd),
    .rst     (RST),
    .pd_up   (pd_up),
    .pd_dn   (pd_dn),
    .clr     (!dll_en),
    .hold    (hold),
    .step_up (step_up_req),
    .step_dn (step_dn_req)
  );

  // A request left over from a cycle when stepping was allowed is dropped.
  assign step_up  = step_up_req && ((state == ST_ACQUIRE) || track);
  assign step_dn  = step_dn_req && ((state == ST_ACQUIRE) || track);
  assign stepping = step_up || step_dn;
  assign step_dir = step_up ? DIR_UP : (step_dn ? DIR_DN : DIR_NONE);
  assign same_dir = stepping && (step_dir == last_dir);
  assign sat_hit  = (step_up && (&dll_code)) || (step_dn && !(|dll_code));

  always_comb begin
    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    win_eff      = (rb_lock_win == '0) ? (CNT_W+1)'(1) : {1'b0, rb_lock_win};
    lock_cnt_nxt = same_dir ? '0 : ({1'b0, lock_cnt} + 1'b1);
    lock_hit     = (lock_cnt_nxt >= win_eff);

    if (!same_dir)     run_cnt_nxt = FILT_W'(1);
    else if (&run_cnt) run_cnt_nxt = run_cnt;
    else               run_cnt_nxt = run_cnt + 1'b1;

    loss_hit = track && stepping && (rb_unlock_thr != '0) && (run_cnt_nxt >= rb_unlock_thr);
  end

  always_ff @(posedge clk_dcd) begin
    if (RST) begin
      state     <= ST_IDLE;
      dll_code  <= rb_code_init;
      dll_lock  <= 1'b0;
      lock_lost <= 1'b0;
      code_sat  <= 1'b0;
      lock_cnt  <= '0;
      run_cnt   <= '0;
      last_dir  <= DIR_NONE;
    end else begin
      lock_lost <= 1'b0;
      if (!dll_en) begin
        // Code and last direction survive a disable so re-enable resumes from here.
        state    <= ST_IDLE;
        dll_lock <= 1'b0;
        code_sat <= 1'b0;
        lock_cnt <= '0;
        run_cnt  <= '0;
      end else begin
        if (stepping) begin
          last_dir <= step_dir;
          if (sat_hit)      code_sat <= 1'b1;
          else if (step_up) dll_code <= dll_code + 1'b1;
          else              dll_code <= dll_code - 1'b1;
        end

        case (state)
          ST_IDLE: state <= ST_ACQUIRE;

          ST_ACQUIRE: begin
            if (lock_hit) begin
              state    <= ST_LOCKED;
              dll_lock <= 1'b1;
              lock_cnt <= '0;
              run_cnt  <= '0;
            end else begin
              lock_cnt <= lock_cnt_nxt[CNT_W-1:0];
            end
          end

          ST_LOCKED: begin
            if (track && stepping) begin
              if (loss_hit) begin
                state     <= ST_ACQUIRE;
                dll_lock  <= 1'b0;
                lock_lost <= 1'b1;
                lock_cnt  <= '0;
                run_cnt   <= '0;
              end else begin
                run_cnt <= run_cnt_nxt;
              end
            end
          end

          default: begin
            state    <= ST_IDLE;
            dll_lock <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aibcr3_dll_lock_ctrl.sv
// Bench for aibcr3_dll_lock_ctrl: directed scenarios followed by randomized
// votes and control, all compared each cycle against a behavioural model.
module tb_aibcr3_dll_lock_ctrl;

  localparam int CODE_W   = 7;
  localparam int CNT_W    = 8;
  localparam int FILT_W   = 3;
  localparam int FTH      = 2**FILT_W - 1;
  localparam int CODE_MAX = 2**CODE_W - 1;
  localparam int RUN_MAX  = 2**FILT_W - 1;

  localparam int M_IDLE = 0;
  localparam int M_ACQ  = 1;
  localparam int M_LCK  = 2;

  logic              clk_dcd = 1'b0;
  logic              RST;
  logic              dll_en;
  logic              pd_up;
  logic              pd_dn;
  logic [CODE_W-1:0] rb_code_init;
  logic [CNT_W-1:0]  rb_lock_win;
  logic [FILT_W-1:0] rb_unlock_thr;
  logic              rb_cont_cal;
  logic [CODE_W-1:0] dll_code;
  logic              dll_lock;
  logic              lock_lost;
  logic              code_sat;

  always #5 clk_dcd = ~clk_dcd;

  aibcr3_dll_lock_ctrl #(
    .CODE_W (CODE_W),
    .CNT_W  (CNT_W),
    .FILT_W (FILT_W)
  ) dut (
    .clk_dcd       (clk_dcd),
    .RST           (RST),
    .dll_en        (dll_en),
    .pd_up         (pd_up),
    .pd_dn         (pd_dn),
    .rb_code_init  (rb_code_init),
    .rb_lock_win   (rb_lock_win),
    .rb_unlock_thr (rb_unlock_thr),
    .rb_cont_cal   (rb_cont_cal),
    .dll_code      (dll_code),
    .dll_lock      (dll_lock),
    .lock_lost     (lock_lost),
    .code_sat      (code_sat)
  );

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  // Reference model: vote sum, pending step (+1/-1/0), counters as plain ints.
  int m_code, m_acc, m_pend, m_lcnt, m_run, m_last, m_st;
  bit m_lock, m_lost, m_sat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  vote, sum, step, nc, win;
    bit  same;
    vote = (pd_up && !pd_dn) ? 1 : ((pd_dn && !pd_up) ? -1 : 0);
    if (RST) begin
      m_code = int'(rb_code_init);
      m_lock = 0; m_lost = 0; m_sat = 0;
      m_acc = 0; m_pend = 0; m_lcnt = 0; m_run = 0; m_last = 0; m_st = M_IDLE;
      return;
    end
    m_lost = 0;
    if (!dll_en) begin
      m_st = M_IDLE; m_lock = 0; m_sat = 0;
      m_acc = 0; m_pend = 0; m_lcnt = 0; m_run = 0;
      return;
    end
    step = ((m_st == M_ACQ) || (m_st == M_LCK && rb_cont_cal)) ? m_pend : 0;
    if (m_st == M_IDLE || (m_st == M_LCK && !rb_cont_cal)) begin
      m_acc = 0; m_pend = 0;
    end else begin
      sum = m_acc + vote;
      if (sum == FTH)       begin m_pend = 1;  m_acc = 0; end
      else if (sum == -FTH) begin m_pend = -1; m_acc = 0; end
      else                  begin m_pend = 0;  m_acc = sum; end
    end
    if (step != 0) begin
      nc = m_code + step;
      if (nc < 0 || nc > CODE_MAX) m_sat = 1;
      else m_code = nc;
    end
    same = (step != 0) && (step == m_last);
    if (step != 0) m_last = step;
    win = (rb_lock_win == 0) ? 1 : int'(rb_lock_win);
    case (m_st)
      M_IDLE: m_st = M_ACQ;
      M_ACQ: begin
        m_lcnt = same ? 0 : m_lcnt + 1;
        if (m_lcnt >= win) begin
          m_st = M_LCK; m_lock = 1; m_lcnt = 0; m_run = 0;
        end
      end
      default: begin
        if (rb_cont_cal && step != 0) begin
          m_run = same ? ((m_run + 1 > RUN_MAX) ? RUN_MAX : m_run + 1) : 1;
          if (rb_unlock_thr != 0 && m_run >= int'(rb_unlock_thr)) begin
            m_st = M_ACQ; m_lock = 0; m_lost = 1; m_lcnt = 0; m_run = 0;
          end
        end
      end
    endcase
  endtask

  task automatic cyc(input logic up, input logic dn);
    pd_up = up;
    pd_dn = dn;
    @(posedge clk_dcd);
    model_edge();
    #1;
    check({phase, ".code"}, 32'(dll_code),  32'(m_code));
    check({phase, ".lock"}, 32'(dll_lock),  32'(m_lock));
    check({phase, ".lost"}, 32'(lock_lost), 32'(m_lost));
    check({phase, ".sat"},  32'(code_sat),  32'(m_sat));
  endtask

  initial begin
    int n, pulses, mode;
    bit got;

    RST = 1'b1; dll_en = 1'b1; pd_up = 1'b0; pd_dn = 1'b0;
    rb_code_init = 7'd40; rb_lock_win = 8'd16; rb_unlock_thr = 3'd0; rb_cont_cal = 1'b0;

    // 1: reset, then 14 counted up votes -> 41 then 42, no lock.
    phase = "t1";
    cyc(0, 0);
    check("t1.rst_code", 32'(dll_code), 32'd40);
    check("t1.rst_flags", {29'd0, dll_lock, lock_lost, code_sat}, 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cyc(1, 0);
      if (i == 7) check("t1.code_before_step", 32'(dll_code), 32'd40);
      if (i == 8) check("t1.code_first_step", 32'(dll_code), 32'd41);
    end
    cyc(0, 0);
    check("t1.code_second_step", 32'(dll_code), 32'd42);
    check("t1.no_lock", 32'(dll_lock), 32'd0);

    // 2: 7 up / 7 dn dither; lock 16 cycles after the last same-direction step.
    phase = "t2";
    n = 0; got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      cyc(((i / 7) % 2) == 0, ((i / 7) % 2) == 1);
      n++;
      if (dll_lock) got = 1;
    end
    check("t2.locked", 32'(got), 32'd1);
    check("t2.lock_cycle", 32'(n), 32'd24);
    check("t2.dither_code", 32'(dll_code), 32'd43);

    // 3: frozen lock ignores votes.
    phase = "t3";
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(1, 0);
      if (lock_lost) pulses++;
    end
    check("t3.code_frozen", 32'(dll_code), 32'd43);
    check("t3.still_locked", 32'(dll_lock), 32'd1);
    check("t3.no_lost", 32'(pulses), 32'd0);

    // 4: tracking, 3 consecutive DN steps declare loss; then relock.
    phase = "t4";
    rb_cont_cal = 1'b1; rb_unlock_thr = 3'd3;
    pulses = 0;
    for (int i = 0; i < 22; i++) begin
      cyc(0, 1);
      if (lock_lost) pulses++;
    end
    check("t4.lost_now", 32'(lock_lost), 32'd1);
    check("t4.unlocked", 32'(dll_lock), 32'd0);
    check("t4.code_after_3dn", 32'(dll_code), 32'd40);
    check("t4.one_pulse", 32'(pulses), 32'd1);
    cyc(0, 0);
    check("t4.pulse_single_cycle", 32'(lock_lost), 32'd0);
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      cyc(((i / 7) % 2) == 0, ((i / 7) % 2) == 1);
      if (dll_lock) got = 1;
    end
    check("t4.relocked", 32'(got), 32'd1);

    // 5: up request at all-ones holds the code and sets the sticky flag.
    phase = "t5";
    RST = 1'b1; rb_code_init = 7'd127; rb_cont_cal = 1'b0;
    cyc(0, 0);
    RST = 1'b0;
    for (int i = 0; i < 8; i++) cyc(1, 0);
    cyc(0, 0);
    check("t5.code_held", 32'(dll_code), 32'd127);
    check("t5.sat_set", 32'(code_sat), 32'd1);
    for (int i = 0; i < 5; i++) cyc(0, 0);
    check("t5.sat_sticky", 32'(code_sat), 32'd1);
    dll_en = 1'b0;
    cyc(0, 0);
    check("t5.sat_cleared", 32'(code_sat), 32'd0);
    dll_en = 1'b1;

    // 6: disable while locked, then reset mid-acquire.
    phase = "t6";
    RST = 1'b1; rb_code_init = 7'd64; rb_lock_win = 8'd4;
    cyc(0, 0);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) cyc(0, 0);
    check("t6.locked", 32'(dll_lock), 32'd1);
    dll_en = 1'b0;
    cyc(0, 0);
    check("t6.dis_unlock", 32'(dll_lock), 32'd0);
    check("t6.dis_no_pulse", 32'(lock_lost), 32'd0);
    check("t6.dis_code_kept", 32'(dll_code), 32'd64);
    dll_en = 1'b1; rb_lock_win = 8'd16;
    for (int i = 0; i < 12; i++) cyc(0, 1);
    check("t6.stepped", 32'(dll_code), 32'd63);
    RST = 1'b1; rb_code_init = 7'd10;
    cyc(1, 0);
    check("t6.rst_code", 32'(dll_code), 32'd10);
    check("t6.rst_flags", {29'd0, dll_lock, lock_lost, code_sat}, 32'd0);
    RST = 1'b0;

    // Randomized votes and control against the model.
    phase = "rand";
    mode = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 24 == 0) mode = $urandom_range(0, 3);
      if ($urandom_range(0, 299) == 0) begin
        RST = 1'b1;
        rb_code_init = CODE_W'($urandom_range(0, CODE_MAX));
      end else begin
        RST = 1'b0;
      end
      dll_en = ($urandom_range(0, 249) != 0);
      if ($urandom_range(0, 99) == 0) rb_cont_cal = ~rb_cont_cal;
      if ($urandom_range(0, 199) == 0) rb_unlock_thr = FILT_W'($urandom_range(0, RUN_MAX));
      if ($urandom_range(0, 199) == 0) rb_lock_win = CNT_W'($urandom_range(0, 20));
      case (mode)
        0:       cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 1);
        1:       cyc($urandom_range(0, 9) < 1, $urandom_range(0, 9) < 8);
        2:       cyc(((i / 7) % 2) == 0, ((i / 7) % 2) == 1);
        default: cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
